// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// the NOP encoding, opcode values and instruction field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_ERR
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Field positions: opcode in the top six bits, jump target in the low 26.
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int TGT_W  = 26;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and memory.
interface instr_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or fall-through.
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic signed [31:0] br_off;

    // Branch immediate lives in the low 16 bits of the same field as the jump target.
    assign br_off = {{14{target[15]}}, target[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, fetches one instruction per step over a req/ack
// bus, holds it for execution, then advances the PC when the datapath is done.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instr,
    output logic [5:0]                 opcode,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    input  logic                       branch,
    input  logic                       alu_zero,
    input  logic                       jump,
    input  logic                       exec_done,
    output logic                       fetch_err
);

    localparam int WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [WCW-1:0] wait_cnt;
    logic           timeout;
    logic [31:0]    next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem.addr = pc;
    assign timeout   = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
    assign opcode    = instr_valid ? instr[OPC_HI:OPC_LO] : 6'd0;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .target   (instr[TGT_W-1:0]),
        .branch   (branch),
        .alu_zero (alu_zero),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_BOOT:  state_next = S_FETCH;
            S_FETCH: begin
                if (imem.ack) begin
                    state_next = S_EXEC;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_EXEC:  if (exec_done) state_next = S_FETCH;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_BOOT;
        endcase
    end

    // Bus request and valid are pure state decodes so no input reaches them combinationally.
    always_comb begin
        imem.req    = (state == S_FETCH);
        instr_valid = (state == S_EXEC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            instr     <= NOP_INSTR;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            unique case (state)
                S_BOOT: wait_cnt <= '0;
                S_FETCH: begin
                    if (imem.ack) begin
                        instr <= imem.rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout) fetch_err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        pc       <= next_pc;
                        wait_cnt <= '0;
                    end
                end
                S_ERR: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, sequential flow, branches,
// jump priority, fetch timeout and reset during an outstanding fetch.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        alu_zero;
    logic        jump;
    logic        exec_done;
    logic        fetch_err;

    int compared = 0;
    int mismatched = 0;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus.master),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .jump        (jump),
        .exec_done   (exec_done),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Entered with the unit in S_FETCH at exp_addr; fetches word, executes it, returns in S_FETCH.
    task automatic step(input string tag, input logic [31:0] word, input logic [5:0] exp_op,
                        input logic br, input logic z, input logic j,
                        input logic [31:0] exp_addr, input logic [31:0] exp_next);
        check({tag, ".req"},  32'(imem_bus.req), 32'd1);
        check({tag, ".addr"}, imem_bus.addr, exp_addr);
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = word;
        tick();
        imem_bus.ack = 1'b0;
        check({tag, ".valid"},  32'(instr_valid), 32'd1);
        check({tag, ".instr"},  instr, word);
        check({tag, ".opcode"}, 32'(opcode), 32'(exp_op));
        check({tag, ".pc"},     pc, exp_addr);
        check({tag, ".pc4"},    pc_plus4, exp_addr + 32'd4);
        check({tag, ".reqx"},   32'(imem_bus.req), 32'd0);
        exec_done = 1'b1;
        branch    = br;
        alu_zero  = z;
        jump      = j;
        tick();
        exec_done = 1'b0;
        branch    = 1'b0;
        alu_zero  = 1'b0;
        jump      = 1'b0;
        check({tag, ".nvalid"}, 32'(instr_valid), 32'd0);
        check({tag, ".nop"},    32'(opcode), 32'd0);
        check({tag, ".next"},   imem_bus.addr, exp_next);
    endtask

    initial begin
        reset          = 1'b1;
        branch         = 1'b0;
        alu_zero       = 1'b0;
        jump           = 1'b0;
        exec_done      = 1'b0;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;
        tick();
        tick();
        check("rst.req",   32'(imem_bus.req), 32'd0);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.pc",    pc, 32'h0);
        check("rst.instr", instr, 32'h0);
        check("rst.err",   32'(fetch_err), 32'd0);
        check("rst.op",    32'(opcode), 32'd0);

        // Boot cycle keeps req low; an early ack here must not be taken.
        reset          = 1'b0;
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'hFFFF_FFFF;
        check("boot.req", 32'(imem_bus.req), 32'd0);
        tick();
        imem_bus.ack = 1'b0;
        check("boot.valid", 32'(instr_valid), 32'd0);

        step("lw",    32'h8C08_0004, OP_LW,    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);
        step("add",   32'h0109_5020, OP_RTYPE, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0008);
        step("sw",    32'hAC08_0008, OP_SW,    1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_000C);
        step("add2",  32'h0109_5020, OP_RTYPE, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0010);
        step("beqT",  32'h1000_FFFE, OP_BEQ,   1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_000C);
        step("add3",  32'h0109_5020, OP_RTYPE, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0010);
        step("beqN",  32'h1000_FFFE, OP_BEQ,   1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0014);
        step("jmax",  32'h0BFF_FFFF, OP_J,     1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h0FFF_FFFC);
        step("nop",   32'h0000_0000, OP_RTYPE, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC, 32'h1000_0000);
        step("jprio", 32'h0800_0040, OP_J,     1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'h1000_0100);

        // Ack withheld: sixteen request cycles, then the sticky error.
        for (int i = 0; i < 16; i++) begin
            check("to.req", 32'(imem_bus.req), 32'd1);
            check("to.err", 32'(fetch_err), 32'd0);
            tick();
        end
        check("to.reqdrop", 32'(imem_bus.req), 32'd0);
        check("to.errset",  32'(fetch_err), 32'd1);
        check("to.valid",   32'(instr_valid), 32'd0);
        check("to.pc",      pc, 32'h1000_0100);
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h8C08_0004;
        exec_done      = 1'b1;
        tick();
        tick();
        imem_bus.ack = 1'b0;
        exec_done    = 1'b0;
        check("err.sticky", 32'(fetch_err), 32'd1);
        check("err.req",    32'(imem_bus.req), 32'd0);
        check("err.valid",  32'(instr_valid), 32'd0);
        check("err.pc",     pc, 32'h1000_0100);

        // Reset out of the error state, then reset again while a fetch is outstanding.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2.err", 32'(fetch_err), 32'd0);
        tick();
        check("rst2.req",  32'(imem_bus.req), 32'd1);
        check("rst2.addr", imem_bus.addr, 32'h0);
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'hDEAD_BEEF;
        check("mid.reqlow", 32'(imem_bus.req), 32'd0);
        tick();
        imem_bus.ack = 1'b0;
        check("mid.instr", instr, 32'h0);
        check("mid.valid", 32'(instr_valid), 32'd0);
        check("mid.pc",    pc, 32'h0);
        check("mid.req",   32'(imem_bus.req), 32'd1);
        tick();
        check("mid.stillfetch", 32'(imem_bus.req), 32'd1);
        check("mid.stillnov",   32'(instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
